pe_load_ctrl: RTL

- Initiator for the PE-array load/pop interface.
- Accepts a weight stream over a valid/ready handshake and drives load beats (valid, PE id, data) into the head of the PE chain, in PE-major, slot-minor order.
- After loading, issues a programmable-length burst of pop-valid pulses that step the PEs through their stored weight slots.
- Sits between the weight buffer and the systolic array.

---
 rtl/pe_load_ctrl_if.sv | 42 ++++
 rtl/pe_load_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pe_load_ctrl_if.sv
// Load/pop bus between the PE-array load controller (master) and its environment (slave).
// o_stall_cnt exists only when PE_LOAD_STALL_CNT_EN is defined.
interface pe_load_ctrl_if #(
  parameter int ID_WIDTH      = 6,
  parameter int IN_DATA_WIDTH = 8,
  parameter int POP_LEN_WIDTH = 16
);
  logic                     i_load_start;
  logic                     s_wgt_vld;
  logic                     s_wgt_rdy;
  logic [IN_DATA_WIDTH-1:0] s_wgt_data;
  logic                     o_load_vld;
  logic [ID_WIDTH-1:0]      o_load_id;
  logic [IN_DATA_WIDTH-1:0] o_load_data;
  logic                     i_pop_start;
  logic [POP_LEN_WIDTH-1:0] i_pop_len;
  logic                     o_pop_vld;
  logic                     o_busy;
  logic                     o_load_done;
  logic                     o_pop_done;
`ifdef PE_LOAD_STALL_CNT_EN
  logic [15:0]              o_stall_cnt;
`endif

  modport master (
    input  i_load_start, s_wgt_vld, s_wgt_data, i_pop_start, i_pop_len,
    output s_wgt_rdy, o_load_vld, o_load_id, o_load_data, o_pop_vld,
           o_busy, o_load_done, o_pop_done
`ifdef PE_LOAD_STALL_CNT_EN
    , output o_stall_cnt
`endif
  );

  modport slave (
    output i_load_start, s_wgt_vld, s_wgt_data, i_pop_start, i_pop_len,
    input  s_wgt_rdy, o_load_vld, o_load_id, o_load_data, o_pop_vld,
           o_busy, o_load_done, o_pop_done
`ifdef PE_LOAD_STALL_CNT_EN
    , input o_stall_cnt
`endif
  );
endinterface

// File: rtl/pe_load_ctrl.sv
// PE-array load/pop initiator: streams weights into the PE chain in PE-major order, then pops.
// Optional stall counter enabled by defining PE_LOAD_STALL_CNT_EN.
//
// state | meaning
// IDLE  | waiting for i_load_start / i_pop_start
// LOAD  | accepting weights, one registered load beat per accept
// POP   | issuing pop_rem consecutive pop-valid pulses
module pe_load_ctrl #(
  parameter int NUM_PE        = 64,
  parameter int ID_WIDTH      = 6,
  parameter int IN_DATA_WIDTH = 8,
  parameter int WGT_DEPTH     = 2,
  parameter int POP_LEN_WIDTH = 16
) (
  input logic          clk,
  input logic          rst,
  pe_load_ctrl_if.master bus
);
  localparam int SLOT_WIDTH = (WGT_DEPTH > 1) ? $clog2(WGT_DEPTH) : 1;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_POP  = 2'd2;
  localparam logic [ID_WIDTH-1:0]      LAST_PE   = ID_WIDTH'(NUM_PE - 1);
  localparam logic [SLOT_WIDTH-1:0]    LAST_SLOT = SLOT_WIDTH'(WGT_DEPTH - 1);
  localparam logic [POP_LEN_WIDTH-1:0] POP_ONE   = POP_LEN_WIDTH'(1);
  localparam logic [POP_LEN_WIDTH-1:0] POP_TWO   = POP_LEN_WIDTH'(2);

  logic [1:0]               state_q, state_d;
  logic [ID_WIDTH-1:0]      pe_cnt_q, pe_cnt_d;
  logic [SLOT_WIDTH-1:0]    slot_cnt_q, slot_cnt_d;
  logic [POP_LEN_WIDTH-1:0] pop_rem_q, pop_rem_d;
  logic                     load_vld_q, load_vld_d;
  logic [ID_WIDTH-1:0]      load_id_q, load_id_d;
  logic [IN_DATA_WIDTH-1:0] load_data_q, load_data_d;
  logic                     pop_vld_q, pop_vld_d;
  logic                     load_done_q, load_done_d;
  logic                     pop_done_q, pop_done_d;
  logic                     start_load, start_pop, accept, last_beat;

  assign start_load = (state_q == ST_IDLE) && bus.i_load_start;
  assign start_pop  = (state_q == ST_IDLE) && !bus.i_load_start && bus.i_pop_start &&
                      (bus.i_pop_len != '0);
  assign accept     = (state_q == ST_LOAD) && bus.s_wgt_vld;
  assign last_beat  = (pe_cnt_q == LAST_PE) && (slot_cnt_q == LAST_SLOT);

  always_comb begin
    state_d     = state_q;
    pe_cnt_d    = pe_cnt_q;
    slot_cnt_d  = slot_cnt_q;
    pop_rem_d   = pop_rem_q;
    load_vld_d  = 1'b0;
    load_id_d   = load_id_q;
    load_data_d = load_data_q;
    pop_vld_d   = 1'b0;
    load_done_d = 1'b0;
    pop_done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_load) begin
          state_d    = ST_LOAD;
          pe_cnt_d   = '0;
          slot_cnt_d = '0;
        end else if (start_pop) begin
          // First pulse is registered on the entry edge so the burst is exactly i_pop_len long.
          state_d    = ST_POP;
          pop_rem_d  = bus.i_pop_len;
          pop_vld_d  = 1'b1;
          pop_done_d = (bus.i_pop_len == POP_ONE);
        end
      end
      ST_LOAD: begin
        if (accept) begin
          load_vld_d  = 1'b1;
          load_id_d   = pe_cnt_q;
          load_data_d = bus.s_wgt_data;
          if (last_beat) begin
            load_done_d = 1'b1;
            state_d     = ST_IDLE;
            pe_cnt_d    = '0;
            slot_cnt_d  = '0;
          end else if (slot_cnt_q == LAST_SLOT) begin
            slot_cnt_d = '0;
            pe_cnt_d   = pe_cnt_q + 1'b1;
          end else begin
            slot_cnt_d = slot_cnt_q + 1'b1;
          end
        end
      end
      ST_POP: begin
        if (pop_rem_q == POP_ONE) begin
          state_d   = ST_IDLE;
          pop_rem_d = '0;
        end else begin
          pop_rem_d  = pop_rem_q - 1'b1;
          pop_vld_d  = 1'b1;
          pop_done_d = (pop_rem_q == POP_TWO);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pe_cnt_q    <= '0;
      slot_cnt_q  <= '0;
      pop_rem_q   <= '0;
      load_vld_q  <= 1'b0;
      load_id_q   <= '0;
      load_data_q <= '0;
      pop_vld_q   <= 1'b0;
      load_done_q <= 1'b0;
      pop_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pe_cnt_q    <= pe_cnt_d;
      slot_cnt_q  <= slot_cnt_d;
      pop_rem_q   <= pop_rem_d;
      load_vld_q  <= load_vld_d;
      load_id_q   <= load_id_d;
      load_data_q <= load_data_d;
      pop_vld_q   <= pop_vld_d;
      load_done_q <= load_done_d;
      pop_done_q  <= pop_done_d;
    end
  end

`ifdef PE_LOAD_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (start_load)
      stall_cnt_d = '0;
    else if ((state_q == ST_LOAD) && !bus.s_wgt_vld && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign bus.o_stall_cnt = stall_cnt_q;
`endif

  assign bus.s_wgt_rdy   = (state_q == ST_LOAD);
  assign bus.o_busy      = (state_q != ST_IDLE);
  assign bus.o_load_vld  = load_vld_q;
  assign bus.o_load_id   = load_id_q;
  assign bus.o_load_data = load_data_q;
  assign bus.o_pop_vld   = pop_vld_q;
  assign bus.o_load_done = load_done_q;
  assign bus.o_pop_done  = pop_done_q;
endmodule
